// File: rtl/mvu_icb_csr_target.sv
// ICB responder for the MVU control/status register bank: decodes single-beat
// commands, launches jobs with a start pulse, tracks busy/done and drives the IRQ.
module mvu_icb_csr_target #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icb_cmd_valid,
  output logic             icb_cmd_ready,
  input  logic [31:0]      icb_cmd_addr,
  input  logic             icb_cmd_read,
  input  logic [31:0]      icb_cmd_wdata,
  input  logic [3:0]       icb_cmd_wmask,
  output logic             icb_rsp_valid,
  input  logic             icb_rsp_ready,
  output logic [31:0]      icb_rsp_rdata,
  output logic             icb_rsp_err,
  output logic             mvu_start,
  output logic [31:0]      mvu_src_addr,
  output logic [31:0]      mvu_dst_addr,
  output logic [LEN_W-1:0] mvu_len,
  input  logic             mvu_done,
  output logic             mvu_irq
);

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_SRC    = 8'h08;
  localparam logic [7:0] OFF_DST    = 8'h0C;
  localparam logic [7:0] OFF_LEN    = 8'h10;
  localparam logic [7:0] OFF_IRQEN  = 8'h14;

  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] len_q;
  logic             irqen_q;
  logic             busy_q;
  logic             done_q;

  logic [7:0]  off;
  logic        accept;
  logic        addr_bad;
  logic        wr_en;
  logic        start_req;
  logic        start_err;
  logic        start_ok;
  logic        done_w1c;
  logic [31:0] rd_data;
  logic        unused_ok;

  // Region select happens upstream, so only the low address byte matters.
  assign unused_ok = ^icb_cmd_addr[31:8];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++)
      if (mask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

  // One outstanding response; a completing response frees the slot same cycle.
  assign icb_cmd_ready = !rst && (!icb_rsp_valid || icb_rsp_ready);
  assign accept        = icb_cmd_valid && icb_cmd_ready;
  assign off           = icb_cmd_addr[7:0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    addr_bad  = (off[1:0] != 2'b00) || (off > OFF_IRQEN);
    wr_en     = 1'b0;
    start_req = 1'b0;
    start_err = 1'b0;
    start_ok  = 1'b0;
    done_w1c  = 1'b0;
    rd_data   = '0;
    if (accept && !addr_bad) begin
      if (icb_cmd_read) begin
        case (off)
          OFF_STATUS: rd_data = {30'd0, done_q, busy_q};
          OFF_SRC:    rd_data = src_q;
          OFF_DST:    rd_data = dst_q;
          OFF_LEN:    rd_data = 32'(len_q);
          OFF_IRQEN:  rd_data = {31'd0, irqen_q};
          default:    rd_data = '0;
        endcase
      end else begin
        // Start legality uses the pre-cycle busy, so a coincident done still rejects.
        start_req = (off == OFF_CTRL) && icb_cmd_wmask[0] && icb_cmd_wdata[0];
        start_err = start_req && (busy_q || (len_q == '0));
        start_ok  = start_req && !start_err;
        done_w1c  = (off == OFF_STATUS) && icb_cmd_wmask[0] && icb_cmd_wdata[1];
        wr_en     = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    // NOTE: every register here is a real flop with a defined reset; there is no memory array.
    if (rst) begin
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      irqen_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mvu_start     <= 1'b0;
      mvu_irq       <= 1'b0;
      icb_rsp_valid <= 1'b0;
      icb_rsp_rdata <= '0;
      icb_rsp_err   <= 1'b0;
    end else begin
      mvu_start <= start_ok;
      mvu_irq   <= done_q && irqen_q;

      if (wr_en) begin
        case (off)
          OFF_SRC:   src_q <= merge_bytes(src_q, icb_cmd_wdata, icb_cmd_wmask);
          OFF_DST:   dst_q <= merge_bytes(dst_q, icb_cmd_wdata, icb_cmd_wmask);
          OFF_LEN:   len_q <= LEN_W'(merge_bytes(32'(len_q), icb_cmd_wdata, icb_cmd_wmask));
          OFF_IRQEN: if (icb_cmd_wmask[0]) irqen_q <= icb_cmd_wdata[0];
          default:   ;
        endcase
      end

      if (start_ok)      busy_q <= 1'b1;
      else if (mvu_done) busy_q <= 1'b0;

      // Completion set wins over a same-cycle software clear.
      if (mvu_done)      done_q <= 1'b1;
      else if (done_w1c) done_q <= 1'b0;

      if (accept) begin
        icb_rsp_valid <= 1'b1;
        icb_rsp_rdata <= rd_data;
        icb_rsp_err   <= addr_bad || start_err;
      end else if (icb_rsp_ready) begin
        icb_rsp_valid <= 1'b0;
      end
    end
  end

  assign mvu_src_addr = src_q;
  assign mvu_dst_addr = dst_q;
  assign mvu_len      = len_q;

endmodule

// File: tb/tb_mvu_icb_csr_target.sv
// Randomized bench for mvu_icb_csr_target: a register-map reference model feeds
// a response scoreboard and per-cycle output expectations.
module tb_mvu_icb_csr_target;

  localparam int LEN_W = 16;
  localparam logic [31:0] LEN_MASK = 32'((64'd1 << LEN_W) - 1);

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_addr;
  logic             cmd_read;
  logic [31:0]      cmd_wdata;
  logic [3:0]       cmd_wmask;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             mvu_start;
  logic [31:0]      mvu_src_addr;
  logic [31:0]      mvu_dst_addr;
  logic [LEN_W-1:0] mvu_len;
  logic             mvu_done;
  logic             mvu_irq;

  mvu_icb_csr_target #(.LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_valid (cmd_valid),
    .icb_cmd_ready (cmd_ready),
    .icb_cmd_addr  (cmd_addr),
    .icb_cmd_read  (cmd_read),
    .icb_cmd_wdata (cmd_wdata),
    .icb_cmd_wmask (cmd_wmask),
    .icb_rsp_valid (rsp_valid),
    .icb_rsp_ready (rsp_ready),
    .icb_rsp_rdata (rsp_rdata),
    .icb_rsp_err   (rsp_err),
    .mvu_start     (mvu_start),
    .mvu_src_addr  (mvu_src_addr),
    .mvu_dst_addr  (mvu_dst_addr),
    .mvu_len       (mvu_len),
    .mvu_done      (mvu_done),
    .mvu_irq       (mvu_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: architectural register file plus response bookkeeping.
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] m_src, m_dst, m_len;
  logic        m_irqen, m_busy, m_done;
  logic        e_rsp_valid, e_start, e_irq;
  logic        armed;

  initial begin
    m_src = 0; m_dst = 0; m_len = 0; m_irqen = 0; m_busy = 0; m_done = 0;
    e_rsp_valid = 0; e_start = 0; e_irq = 0; armed = 0;
  end

  function automatic logic [31:0] apply_mask(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] o);
    case (o)
      8'h04:   return {30'd0, m_done, m_busy};
      8'h08:   return m_src;
      8'h0C:   return m_dst;
      8'h10:   return m_len;
      8'h14:   return {31'd0, m_irqen};
      default: return 32'd0;
    endcase
  endfunction

  // Inputs only change just after posedge, so the negedge view equals what the next edge samples.
  always @(negedge clk) begin
    logic       exp_ready, acc, start_ok, clr_done, err;
    logic [7:0] o;
    logic [31:0] rd;
    exp_ready = !rst && (!e_rsp_valid || rsp_ready);

    if (armed) begin
      check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
      check("mvu_start", 32'(mvu_start), 32'(e_start));
      check("mvu_irq",   32'(mvu_irq),   32'(e_irq));
      check("mvu_src",   mvu_src_addr,   m_src);
      check("mvu_dst",   mvu_dst_addr,   m_dst);
      check("mvu_len",   32'(mvu_len),   m_len);
      if (rsp_valid) begin
        if (sb.size() == 0) fail_now("unexpected_response");
        else begin
          check("rsp_rdata", rsp_rdata,       sb[0].rdata);
          check("rsp_err",   32'(rsp_err),    32'(sb[0].err));
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end

    if (rst) begin
      m_src = 0; m_dst = 0; m_len = 0; m_irqen = 0; m_busy = 0; m_done = 0;
      e_rsp_valid = 0; e_start = 0; e_irq = 0;
      sb.delete();
      armed = 1;
    end else begin
      e_irq    = m_done && m_irqen;
      acc      = cmd_valid && exp_ready;
      start_ok = 0;
      clr_done = 0;
      if (acc) begin
        o   = cmd_addr[7:0];
        err = (o % 4 != 0) || (o > 8'h14);
        rd  = 0;
        if (!err) begin
          if (cmd_read) rd = model_read(o);
          else begin
            case (o)
              8'h00: if (cmd_wmask[0] && cmd_wdata[0]) begin
                       if (m_busy || m_len == 0) err = 1;
                       else start_ok = 1;
                     end
              8'h04: clr_done = cmd_wmask[0] && cmd_wdata[1];
              8'h08: m_src = apply_mask(m_src, cmd_wdata, cmd_wmask);
              8'h0C: m_dst = apply_mask(m_dst, cmd_wdata, cmd_wmask);
              8'h10: m_len = apply_mask(m_len, cmd_wdata, cmd_wmask) & LEN_MASK;
              8'h14: if (cmd_wmask[0]) m_irqen = cmd_wdata[0];
              default: ;
            endcase
          end
        end
        sb.push_back('{err: err, rdata: rd});
      end
      e_start = start_ok;
      if (start_ok) m_busy = 1;
      else if (mvu_done) m_busy = 0;
      if (mvu_done) m_done = 1;
      else if (clr_done) m_done = 0;
      if (acc) e_rsp_valid = 1;
      else if (rsp_ready) e_rsp_valid = 0;
    end
  end

  // Stimulus
  logic rand_mode   = 0;
  logic ready_force = 1;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      mvu_done  = ($urandom_range(0, 15) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      mvu_done  = 1'b0;
      rsp_ready = ready_force;
    end
  endtask

  task automatic drive(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] wm, input logic with_done);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wmask = wm;
    if (with_done) mvu_done = 1'b1;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        tick();
        return;
      end
      tick();
    end
    fail_now("cmd_accept_timeout");
    cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
    drive(1'b0, a, wd, wm, 1'b0);
    wait_accept();
  endtask

  task automatic rd_reg(input logic [31:0] a);
    drive(1'b1, a, $urandom, 4'h0, 1'b0);
    wait_accept();
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_done();
    cmd_valid = 1'b0;
    mvu_done  = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1; cmd_valid = 0; cmd_read = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wmask = 0;
    rsp_ready = 1; mvu_done = 0;
    repeat (3) tick();
    rst = 0;
    idle(2);

    // Register access
    wr(32'h08, 32'hDEADBEEF, 4'hF);
    rd_reg(32'h08);
    wr(32'h0C, 32'h0000AB00, 4'h2);
    rd_reg(32'h0C);

    // Job launch, completion, interrupt, W1C
    wr(32'h10, 32'h40, 4'hF);
    wr(32'h14, 32'h1, 4'h1);
    wr(32'h00, 32'h1, 4'h1);
    rd_reg(32'h04);
    wr(32'h00, 32'h1, 4'h1);
    idle(3);
    pulse_done();
    idle(3);
    rd_reg(32'h04);
    wr(32'h04, 32'h2, 4'h1);
    idle(3);

    // Error and no-op cases
    wr(32'h10, 32'h0, 4'hF);
    wr(32'h00, 32'h1, 4'h1);
    rd_reg(32'h18);
    wr(32'h09, 32'h12345678, 4'hF);
    wr(32'h08, 32'h11111111, 4'h0);
    wr(32'h00, 32'hFFFFFFFE, 4'hF);
    wr(32'h10, 32'hFFFF1234, 4'hF);
    rd_reg(32'h10);
    idle(2);

    // Backpressure, then back-to-back reads
    ready_force = 0;
    rd_reg(32'h08);
    drive(1'b1, 32'h0C, 32'h0, 4'h0, 1'b0);
    repeat (5) tick();
    ready_force = 1;
    wait_accept();
    rd_reg(32'h10);
    rd_reg(32'h14);
    rd_reg(32'h04);
    idle(3);

    // Same-cycle done with W1C, and done with start
    pulse_done();
    idle(2);
    drive(1'b0, 32'h04, 32'h2, 4'h1, 1'b1);
    wait_accept();
    rd_reg(32'h04);
    wr(32'h10, 32'h5, 4'hF);
    wr(32'h00, 32'h1, 4'h1);
    drive(1'b0, 32'h00, 32'h1, 4'h1, 1'b1);
    wait_accept();
    rd_reg(32'h04);
    idle(2);

    // Reset while a response is pending and a job is busy
    wr(32'h00, 32'h1, 4'h1);
    ready_force = 0;
    idle(2);
    ready_force = 1;
    idle(2);
    ready_force = 0;
    rd_reg(32'h08);
    cmd_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    ready_force = 1;
    idle(2);
    wr(32'h10, 32'h3, 4'h3);
    wr(32'h00, 32'h1, 4'h1);
    idle(2);
    pulse_done();
    idle(2);

    // Randomized traffic
    rand_mode = 1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 255) << 8} | 32'($urandom_range(0, 7) * 4);
      a[31:8] = 24'($urandom);
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      drive(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
      wait_accept();
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_mode = 0;
    ready_force = 1;
    idle(10);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
